morse_player: RTL and testbench

Transmit side of the Morse game path: takes a 10-bit Morse word (five 2-bit symbols, MSB symbol first) and plays it out as a timed on/off signal for an LED or buzzer. Symbol encoding and word packing match the morse_decoder / player2 receive path, so a word played here can be keyed back in and checked. It sits between player1's stored value and the board output that player2 watches.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_tick_timer.sv | 37 +++
 rtl/morse_player.sv | 124 ++++++++++++
 tb/tb_morse_player.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions for the transmit (morse_player) and receive
// (morse_decoder / player2) paths.
//   - symbol encoding: 00 NONE, 01 DOT, 11 LINE (10 is read as NONE)
//   - word packing: five 2-bit symbols, MSB symbol first
//   - player FSM state encoding
package morse_pkg;

    localparam int MORSE_WORD_W = 10;
    localparam int MORSE_SYM_W  = 2;
    localparam int MORSE_SYMS   = MORSE_WORD_W / MORSE_SYM_W;

    localparam logic [MORSE_SYM_W-1:0] MORSE_NONE = 2'b00;
    localparam logic [MORSE_SYM_W-1:0] MORSE_DOT  = 2'b01;
    localparam logic [MORSE_SYM_W-1:0] MORSE_LINE = 2'b11;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_LOAD,
        PS_ON,
        PS_GAP,
        PS_DONE
    } player_state_t;

    // Only DOT and LINE produce a tone; NONE and the unused 10 are skipped.
    function automatic logic is_sounded(input logic [MORSE_SYM_W-1:0] sym);
        return (sym == MORSE_DOT) || (sym == MORSE_LINE);
    endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// Loadable down-counter used to time tone and gap durations.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   clear         : synchronous clear to 0 (highest priority)
//   load, value   : load `value` into the counter
//   zero          : counter currently holds 0
// The counter counts down by one per cycle while non-zero and parks at 0.
module morse_tick_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/morse_player.sv
// Plays a 10-bit Morse word as a timed on/off key signal.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   start         : play `code` (honoured only in IDLE)
//   abort         : synchronous stop, back to IDLE without `done`
//   code          : Morse word, symbols [9:8] first ... [1:0] last
//   signal_out    : 1 = tone / LED on
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse when a word completes normally
//   sym_idx       : index 0..4 of the symbol being processed
// Tick parameters must each lie in 1..2**CNT_W.
module morse_player
    import morse_pkg::*;
#(
    parameter int DOT_TICKS  = 4,
    parameter int LINE_TICKS = 12,
    parameter int GAP_TICKS  = 4,
    parameter int CNT_W      = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [MORSE_WORD_W-1:0] code,
    output logic                    signal_out,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              sym_idx
);

    // Counter reload values: a duration of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_TICKS - 1);
    localparam logic [CNT_W-1:0] LINE_LOAD = CNT_W'(LINE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(MORSE_SYMS - 1);

    player_state_t          state, next_state;
    logic [MORSE_WORD_W-1:0] shift;
    logic [MORSE_SYM_W-1:0]  sym;
    logic                    last_sym;
    logic                    advance;
    logic                    timer_load;
    logic [CNT_W-1:0]        timer_value;
    logic                    timer_zero;

    assign sym      = shift[MORSE_WORD_W-1 -: MORSE_SYM_W];
    assign last_sym = (sym_idx == LAST_IDX);

    morse_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (abort),
        .load   (timer_load),
        .value  (timer_value),
        .zero   (timer_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= PS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            PS_IDLE: if (start) next_state = PS_LOAD;
            PS_LOAD: begin
                if (is_sounded(sym)) next_state = PS_ON;
                else if (last_sym)   next_state = PS_DONE;
            end
            PS_ON:   if (timer_zero) next_state = PS_GAP;
            PS_GAP: begin
                if (timer_zero) next_state = last_sym ? PS_DONE : PS_LOAD;
            end
            PS_DONE: next_state = PS_IDLE;
            default: next_state = PS_IDLE;
        endcase
        // abort wins everywhere, including over start in IDLE
        if (abort) next_state = PS_IDLE;
    end

    always_comb begin
        signal_out  = (state == PS_ON);
        busy        = (state != PS_IDLE);
        done        = (state == PS_DONE);
        timer_load  = 1'b0;
        timer_value = GAP_LOAD;
        advance     = 1'b0;
        case (state)
            PS_LOAD: begin
                timer_load  = is_sounded(sym);
                timer_value = (sym == MORSE_LINE) ? LINE_LOAD : DOT_LOAD;
                advance     = !abort && !is_sounded(sym);
            end
            PS_ON:  timer_load = timer_zero;
            PS_GAP: advance    = !abort && timer_zero;
            default: ;
        endcase
    end

    // Word shift register and symbol index. The advance past the last symbol
    // returns sym_idx to 0 so it reads 0 in DONE and IDLE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shift   <= '0;
            sym_idx <= '0;
        end else if (abort) begin
            shift   <= '0;
            sym_idx <= '0;
        end else if (state == PS_IDLE && start) begin
            shift   <= code;
            sym_idx <= '0;
        end else if (advance) begin
            shift   <= {shift[MORSE_WORD_W-MORSE_SYM_W-1:0], MORSE_NONE};
            sym_idx <= last_sym ? 3'd0 : sym_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player: hand-computed vector table, directed
// corner sequences and randomized words compared cycle-by-cycle against a
// trace model built from the symbol timing rules.
module tb_morse_player;

    localparam int DOT_T   = 4;
    localparam int LINE_T  = 12;
    localparam int GAP_T   = 4;
    localparam int MAX_OBS = 120;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic [9:0] code   = '0;
    logic       signal_out, busy, done;
    logic [2:0] sym_idx;

    morse_player #(
        .DOT_TICKS  (DOT_T),
        .LINE_TICKS (LINE_T),
        .GAP_TICKS  (GAP_T),
        .CNT_W      (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .code       (code),
        .signal_out (signal_out),
        .busy       (busy),
        .done       (done),
        .sym_idx    (sym_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       sig;
        logic       bsy;
        logic       dn;
        logic [2:0] idx;
    } obs_t;

    typedef struct {
        logic [9:0] code;
        int         exp_len;
        int         exp_on;
        string      name;
    } vec_t;

    obs_t obs [MAX_OBS];
    int   n_obs;
    obs_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Expected per-cycle trace after start: for each symbol, one decode cycle,
    // then T tone cycles and GAP_T silent cycles if it is DOT or LINE; then
    // one done cycle.
    task automatic build_model(input logic [9:0] c);
        logic [1:0] s;
        int         t;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            s = c[9 - 2*i -: 2];
            t = (s == 2'b01) ? DOT_T : (s == 2'b11) ? LINE_T : 0;
            exp_q.push_back(obs_t'{1'b0, 1'b1, 1'b0, 3'(i)});
            if (t > 0) begin
                for (int k = 0; k < t; k++)     exp_q.push_back(obs_t'{1'b1, 1'b1, 1'b0, 3'(i)});
                for (int k = 0; k < GAP_T; k++) exp_q.push_back(obs_t'{1'b0, 1'b1, 1'b0, 3'(i)});
            end
        end
        exp_q.push_back(obs_t'{1'b0, 1'b1, 1'b1, 3'd0});
    endtask

    // Called just after a negedge. Raises start for one edge, then records
    // outputs at each negedge while busy. Optional abort / stray start with a
    // different code at given observation indices (-1 = none).
    task automatic run_word(input logic [9:0] c, input int abort_at, input int poke_at);
        start = 1'b1;
        code  = c;
        @(negedge clock);
        start = 1'b0;
        n_obs = 0;
        while (busy === 1'b1 && n_obs < MAX_OBS) begin
            obs[n_obs] = obs_t'{signal_out, busy, done, sym_idx};
            if (n_obs == poke_at) begin
                start = 1'b1;
                code  = ~c;
            end else begin
                start = 1'b0;
            end
            abort = (n_obs == abort_at);
            n_obs++;
            @(negedge clock);
        end
        start = 1'b0;
        abort = 1'b0;
        check("busy_falls", busy, 0);
    endtask

    task automatic compare_trace(input string name, input int abort_at);
        int   exp_n;
        int   bad;
        obs_t e;
        obs_t a;
        exp_n = exp_q.size();
        bad   = 0;
        if (abort_at >= 0 && abort_at + 1 < exp_n) exp_n = abort_at + 1;
        check({name, "_len"}, n_obs, exp_n);
        for (int k = 0; k < n_obs && k < exp_n; k++) begin
            e = exp_q[k];
            a = obs[k];
            if (a.sig !== e.sig || a.bsy !== e.bsy || a.dn !== e.dn ||
                (!e.dn && a.idx !== e.idx)) begin
                if (bad == 0)
                    $display("  %s diverges at cycle %0d: got sig/busy/done/idx %b%b%b/%0d want %b%b%b/%0d",
                             name, k, a.sig, a.bsy, a.dn, a.idx, e.sig, e.bsy, e.dn, e.idx);
                bad++;
            end
        end
        check({name, "_trace_diffs"}, bad, 0);
    endtask

    function automatic int count_on();
        int s = 0;
        for (int k = 0; k < n_obs; k++) s += int'(obs[k].sig);
        return s;
    endfunction

    function automatic int count_done();
        int s = 0;
        for (int k = 0; k < n_obs; k++) s += int'(obs[k].dn);
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   first_high;
        int   done_at;
        logic [31:0] seq;
        logic [2:0]  last_idx;
        int   runs_hi [$];
        int   runs_lo [$];
        int   run_len;
        logic run_val;
        logic [9:0] rc;
        int   ab, pk;

        vecs[0] = '{10'h100, 14,  4, "single_dot"};
        vecs[1] = '{10'h1D3, 54, 32, "mixed"};
        vecs[2] = '{10'h000,  6,  0, "empty"};
        vecs[3] = '{10'h3FF, 86, 60, "all_line"};
        vecs[4] = '{10'h2AA,  6,  0, "all_10"};
        vecs[5] = '{10'h001, 14,  4, "last_dot"};
        vecs[6] = '{10'h155, 46, 20, "all_dot"};

        // reset state
        #12;
        check("rst_signal_out", signal_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sym_idx", sym_idx, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // vector table, played back-to-back
        for (int v = 0; v < 7; v++) begin
            build_model(vecs[v].code);
            run_word(vecs[v].code, -1, -1);
            check({vecs[v].name, "_busy_len"}, n_obs, vecs[v].exp_len);
            check({vecs[v].name, "_on_cycles"}, count_on(), vecs[v].exp_on);
            check({vecs[v].name, "_done_pulses"}, count_done(), 1);
            compare_trace(vecs[v].name, -1);
        end

        // single dot: rise two cycles after start, index walk, done position
        run_word(10'h100, -1, -1);
        first_high = -1;
        done_at    = -1;
        seq        = 32'h0;
        last_idx   = 3'd7;
        for (int k = 0; k < n_obs; k++) begin
            if (obs[k].sig && first_high < 0) first_high = k;
            if (obs[k].dn) done_at = k;
            else if (obs[k].idx != last_idx) begin
                seq      = (seq << 4) | 32'(obs[k].idx);
                last_idx = obs[k].idx;
            end
        end
        check("dot_first_high", first_high, 1);
        check("dot_idx_seq", seq, 32'h01234);
        check("dot_done_at", done_at, 13);

        // mixed word: tone widths and silent stretches
        run_word(10'h1D3, -1, -1);
        runs_hi.delete();
        runs_lo.delete();
        run_val = obs[0].sig;
        run_len = 0;
        for (int k = 0; k <= n_obs; k++) begin
            if (k < n_obs && obs[k].sig == run_val) run_len++;
            else begin
                if (run_val) runs_hi.push_back(run_len);
                else         runs_lo.push_back(run_len);
                if (k < n_obs) begin
                    run_val = obs[k].sig;
                    run_len = 1;
                end
            end
        end
        check("mixed_pulse_count", runs_hi.size(), 4);
        check("mixed_low_count", runs_lo.size(), 5);
        if (runs_hi.size() == 4 && runs_lo.size() == 5) begin
            check("mixed_w0", runs_hi[0], 4);
            check("mixed_w1", runs_hi[1], 12);
            check("mixed_w2", runs_hi[2], 4);
            check("mixed_w3", runs_hi[3], 12);
            check("mixed_lead_low", runs_lo[0], 1);
            check("mixed_low1", runs_lo[1], 5);
            check("mixed_low2", runs_lo[2], 5);
            check("mixed_low3_none", runs_lo[3], 6);
            check("mixed_tail_low", runs_lo[4], 5);
        end

        // empty word: done on the 6th busy cycle
        run_word(10'h000, -1, -1);
        check("empty_done_flag", obs[5].dn, 1);
        check("empty_on", count_on(), 0);

        // abort on the 5th tone cycle of a line, then replay
        build_model(10'h3C0);
        run_word(10'h3C0, 5, -1);
        compare_trace("abort", 5);
        check("abort_no_done", count_done(), 0);
        check("abort_after_sig", signal_out, 0);
        check("abort_after_done", done, 0);
        run_word(10'h3C0, -1, -1);
        compare_trace("replay", -1);

        // stray start with a different code while busy is ignored
        build_model(10'h1D3);
        run_word(10'h1D3, -1, 3);
        compare_trace("ignored_start", -1);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        code  = 10'h100;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("abort_prio_busy", busy, 0);
        @(negedge clock);
        check("abort_prio_busy2", busy, 0);

        // asynchronous reset during the gap after symbol 1
        start = 1'b1;
        code  = 10'h1D3;
        @(negedge clock);
        start = 1'b0;
        repeat (23) @(negedge clock);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_sig", signal_out, 0);
        check("pre_rst_idx", sym_idx, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sig", signal_out, 0);
        check("async_rst_done", done, 0);
        check("async_rst_idx", sym_idx, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_busy", busy, 0);
        build_model(10'h155);
        run_word(10'h155, -1, -1);
        compare_trace("post_rst", -1);

        // randomized words, occasional abort or stray start
        for (int r = 0; r < 25; r++) begin
            rc = 10'($urandom);
            build_model(rc);
            ab = -1;
            pk = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, exp_q.size() - 1);
            if ($urandom_range(0, 3) == 0) pk = $urandom_range(0, exp_q.size() - 1);
            run_word(rc, ab, pk);
            compare_trace("random", ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
